// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector.
// Holds the detector FSM state type and the default pattern and counter
// geometry that the top-level parameters fall back to.
package seq_det_pkg;

    // FILLING: fewer than PATTERN_W valid bits held. ARMED: history is full.
    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_ARMED   = 1'b1
    } state_t;

    // Default detector geometry: the 4-bit pattern 1011 (MSB oldest).
    localparam int           DEF_PATTERN_W = 4;
    localparam logic [3:0]   DEF_PATTERN   = 4'b1011;
    localparam int           DEF_CNT_W     = 8;

endpackage : seq_det_pkg

// File: rtl/serial_seq_det_sat_counter.sv
// Saturating up-counter used for the match tally.
// It counts inc pulses and sticks at all-ones instead of wrapping.
// rst and clr both zero the count and take priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one on inc unless already at the all-ones ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous zeroing from either reset source.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/serial_seq_det.sv
// Serial sequence detector.
// Shifts in the registered serial stream on din_valid edges, raises a
// one-cycle match pulse when the last PATTERN_W valid bits equal PATTERN
// (MSB = oldest bit), and keeps a saturating tally of matches.
// Build option: define SEQ_DET_OVERLAP_EN to let overlapping occurrences
// each match; by default a hit restarts the fill so the next match needs
// PATTERN_W fresh valid bits.
module serial_seq_det
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
    parameter int                   CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    // fill counts 0..PATTERN_W, so it needs room for PATTERN_W itself.
    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    state_t                 state_q;
    state_t                 state_d;
    logic [PATTERN_W-1:0]   hist_q;
    logic [PATTERN_W-1:0]   hist_d;
    logic [PATTERN_W-1:0]   hist_n;
    logic [FILL_W-1:0]      fill_q;
    logic [FILL_W-1:0]      fill_d;
    logic [FILL_W-1:0]      fill_n;
    logic                   match_q;
    logic                   match_d;
    logic                   hit;

    // Candidate history/fill for a valid edge and the resulting hit flag.
    // A hit needs a full history, so the zeroed history after reset can
    // never produce a false match even when PATTERN happens to be zero.
    always_comb begin
        hist_n = {hist_q[PATTERN_W-2:0], din};
        fill_n = (fill_q == FILL_FULL) ? fill_q : (fill_q + 1'b1);
        hit    = din_valid && (fill_n == FILL_FULL) && (hist_n == PATTERN);
    end

    // FSM next state plus history, fill and pulse next values.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (din_valid) begin
            hist_d  = hist_n;
            fill_d  = fill_n;
            match_d = hit;
            case (state_q)
                ST_FILLING: begin
                    if (fill_n == FILL_FULL) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    state_d = ST_ARMED;
                end
                default: begin
                    state_d = ST_FILLING;
                end
            endcase
`ifdef SEQ_DET_OVERLAP_EN
            // Overlap mode: history and fill are kept after a hit.
`else
            // Non-overlap mode: a hit consumes the history; the shift
            // register keeps shifting but must be refilled before it counts.
            if (hit) begin
                fill_d  = '0;
                state_d = ST_FILLING;
            end
`endif
        end
    end

    // State registers; rst and clear both wipe history and drop the bit
    // offered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= ST_FILLING;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    // Match tally; the counter's own reset priority masks hit during clears.
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (hit),
        .count (match_count)
    );

    assign match = match_q;
    assign armed = (state_q == ST_ARMED);

endmodule : serial_seq_det

// File: tb/tb_serial_seq_det.sv
// Self-checking bench for serial_seq_det (pattern 1011).
// Two instances share the stimulus: one with an 8-bit tally and one with a
// 2-bit tally so saturation is exercised alongside normal counting.
module tb_serial_seq_det;

    localparam int         PW  = 4;
    localparam logic [3:0] PAT = 4'b1011;
`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       m8, m2, a8, a2;
    logic [7:0] c8;
    logic [1:0] c2;

    serial_seq_det #(.PATTERN_W(PW), .PATTERN(PAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .din(din), .din_valid(din_valid),
        .match(m8), .match_count(c8), .armed(a8)
    );

    serial_seq_det #(.PATTERN_W(PW), .PATTERN(PAT), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .din(din), .din_valid(din_valid),
        .match(m2), .match_count(c2), .armed(a2)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the valid bits since the last reset/clear (or since
    // the last consumed hit), newest at the back, trimmed to PW entries.
    bit mq[$];
    int e_cnt8 = 0;
    int e_cnt2 = 0;
    bit e_m = 1'b0;
    bit e_a = 1'b0;

    typedef struct {
        bit r;
        bit c;
        bit v;
        bit d;
        bit em;
        int ec;
        bit ea;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] window();
        logic [3:0] w = '0;
        foreach (mq[i]) w = {w[2:0], mq[i]};
        return w;
    endfunction

    task automatic model(input bit r, input bit c, input bit v, input bit d);
        bit h;
        if (r || c) begin
            mq.delete();
            e_m    = 1'b0;
            e_cnt8 = 0;
            e_cnt2 = 0;
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() > PW) void'(mq.pop_front());
            h   = (mq.size() == PW) && (window() == PAT);
            e_m = h;
            if (h) begin
                if (e_cnt8 < 255) e_cnt8++;
                if (e_cnt2 < 3) e_cnt2++;
                if (!OVL) mq.delete();
            end
        end else begin
            e_m = 1'b0;
        end
        e_a = (mq.size() == PW);
    endtask

    // Drive one cycle, let the edge happen, then advance the model.
    task automatic apply(input string tag, input bit r, input bit c, input bit v, input bit d);
        rst = r; clear = c; din_valid = v; din = d;
        @(posedge clk);
        #1;
        model(r, c, v, d);
        $display("%s rst=%0d clr=%0d vld=%0d din=%0d -> match=%0d cnt=%0d armed=%0d",
                 tag, r, c, v, d, m8, c8, a8);
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit v, input bit d);
        apply(tag, r, c, v, d);
        check({tag, ".match"},   m8, e_m);
        check({tag, ".match_s"}, m2, e_m);
        check({tag, ".cnt"},     c8, e_cnt8);
        check({tag, ".cnt_s"},   c2, e_cnt2);
        check({tag, ".armed"},   a8, e_a);
        check({tag, ".armed_s"}, a2, e_a);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [3:0] pat_v;
        pat_v = PAT;

        // Reset, single match, overlap stream, reset after armed, dropped bit.
        tbl[0]  = '{1, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 1, 1, OVL};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, OVL};
        tbl[8]  = '{0, 0, 1, 0, 0, 1, OVL};
        tbl[9]  = '{0, 0, 1, 1, 0, 1, OVL};
        tbl[10] = '{0, 0, 1, 1, OVL, OVL ? 2 : 1, OVL};
        tbl[11] = '{0, 0, 0, 1, 0, OVL ? 2 : 1, OVL};
        tbl[12] = '{0, 0, 1, 0, 0, OVL ? 2 : 1, 1};
        tbl[13] = '{1, 0, 1, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 1, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            apply("tbl", tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d);
            check("tbl.match",   m8, tbl[i].em);
            check("tbl.cnt",     c8, tbl[i].ec);
            check("tbl.cnt_s",   c2, tbl[i].ec);
            check("tbl.armed",   a8, tbl[i].ea);
        end

        // Valid gaps with din toggling while invalid.
        step("gap", 1, 0, 0, 0);
        for (int b = 3; b >= 0; b--) begin
            step("gap", 0, 0, 1, pat_v[b]);
            step("gap", 0, 0, 0, 1'b1);
            step("gap", 0, 0, 0, 1'b0);
        end
        check("gap.final_cnt", c8, 1);

        // Saturation on the 2-bit tally: 1011 five times.
        step("sat", 1, 0, 0, 0);
        pulses = 0;
        for (int rep = 0; rep < 5; rep++) begin
            for (int b = 3; b >= 0; b--) begin
                step("sat", 0, 0, 1, pat_v[b]);
                if (m2) pulses++;
            end
            check("sat.cnt_s", c2, (rep < 3) ? rep + 1 : 3);
            check("sat.cnt", c8, rep + 1);
        end
        check("sat.pulses", pulses, 5);

        // Clear mid-pattern, with a valid bit offered in the clear cycle.
        step("clr", 1, 0, 0, 0);
        step("clr", 0, 0, 1, 1);
        step("clr", 0, 0, 1, 0);
        step("clr", 0, 0, 1, 1);
        step("clr", 0, 1, 1, 1);
        pulses = 0;
        for (int b = 3; b >= 0; b--) begin
            step("clr", 0, 0, 1, pat_v[b]);
            if (b > 0 && m8) pulses++;
        end
        check("clr.early_match", pulses, 0);
        check("clr.final_match", m8, 1);
        check("clr.final_cnt", c8, 1);

        // Randomized traffic against the model.
        step("rnd", 1, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            step("rnd",
                 ($urandom_range(63) == 0),
                 ($urandom_range(63) == 0),
                 ($urandom_range(3) != 0),
                 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_seq_det
